simplebus_leader_ctrl: RTL and testbench
========================================

# simplebus_leader_ctrl

Synthesizable leader-side controller for the simplebus protocol. Replaces task-driven processor stimulus with a client request/response port. Client transactions are translated into the two-cycle address phase followed by a read-wait or write-data phase. Bus tristates are split into out/oe/in signals; the top-level wrapper ties them to the interface `tri` nets. A read timeout keeps the client from hanging on an absent follower.

## Interface
- `TIMEOUT`, default 16: max cycles spent in RDWAIT before aborting; legal range 2..255.
- `clock`  in  1  bus clock; all state updates on posedge.
- `resetN`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  transaction address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; valid with `rsp_valid`.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: read aborted.
- `bus_start`  out  1  drives bus `start`.
- `bus_read`  out  1  drives bus `read`.
- `bus_addr_out`, `bus_addr_oe`  out  8, 1  bus `address` value / enable.
- `bus_data_out`, `bus_data_oe`  out  8, 1  bus `data` value / enable.
- `bus_data_in`  in  8  resolved bus `data`.
- `bus_dv_out`, `bus_dv_oe`  out  1, 1  bus `dataValid` value / enable.
- `bus_dv_in`  in  1  resolved bus `dataValid`.

## Operation
- States:
  - IDLE → UPPER on `req_valid && req_ready`. At that edge, latch `req_addr`, `req_write`, `req_wdata`.
  - UPPER → LOWER unconditionally.
  - LOWER → RDWAIT for a read; LOWER → WRDATA for a write.
  - RDWAIT → IDLE on `bus_dv_in` = 1, or on timeout.
  - WRDATA → IDLE unconditionally.
- Bus outputs are combinational from state and latched request; no other output depends on `req_*` combinationally.
- UPPER: `bus_start`=1; `bus_addr_out`=addr[15:8]; `bus_addr_oe`=1.
- LOWER: `bus_addr_out`=addr[7:0]; `bus_addr_oe`=1; `bus_read`=~write.
- RDWAIT:
  - All `*_oe`=0.
  - When `bus_dv_in` is sampled 1, capture `bus_data_in` into `rsp_rdata`.
  - Counter clears on RDWAIT entry and increments each RDWAIT cycle. Timeout occurs when count reaches `TIMEOUT`-1 with no dataValid.
  - On timeout, `rsp_rdata`=8'hFF and `rsp_timeout`=1.
- WRDATA, exactly one cycle: `bus_data_out`=wdata; `bus_data_oe`=1; `bus_dv_out`=1; `bus_dv_oe`=1.
- `bus_dv_oe` is high only in WRDATA, so the leader never drives dataValid while the follower may be driving it.
- `rsp_valid` is registered and pulses one cycle in the IDLE cycle after RDWAIT/WRDATA exit. `req_ready` is high in that same cycle, so back-to-back requests are allowed.
- `rsp_rdata` holds its value until the next read completes. Write completions leave it unchanged and set `rsp_timeout`=0.
- After a timeout the follower state is undefined. The client must reset the bus before issuing further traffic; the controller itself keeps accepting requests.

## Timing
- Reset (async, immediate):
  - State = IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_timeout`=0, `rsp_rdata`=8'h00.
  - `bus_start`=`bus_read`=0.
  - All `*_oe`=0 and all `*_out`=0.
  - Timeout counter = 0.
  - Reset mid-transaction aborts without generating a response.
- Request accepted at edge k:
  - Cycle k..k+1: UPPER.
  - Cycle k+1..k+2: LOWER.
  - Write: WRDATA in k+2..k+3; `rsp_valid` in k+3..k+4. Write latency is 4 edges from acceptance to response sampled.
- Read with dataValid sampled at edge k+2+n (n ≥ 1): `rsp_valid` high in cycle k+2+n..k+3+n.
- Timeout: RDWAIT occupies exactly `TIMEOUT` cycles, then `rsp_valid` with `rsp_timeout`=1.
- If dataValid arrives in the same cycle the counter hits its limit, dataValid wins: normal response, `rsp_timeout`=0.
- `req_valid` outside IDLE is ignored; the client holds it until `req_ready`.

## Test plan
- Reset check: assert resetN=0 mid-UPPER → all oe=0, `bus_start`=0, `req_ready`=1 asynchronously; no `rsp_valid` afterwards.
- Write 16'h0406 ← 8'hDC against the memory follower:
  - `bus_addr_out`=8'h04 with `bus_start`=1, then 8'h06 with `bus_read`=0.
  - One cycle of `bus_data_out`=8'hDC with `bus_dv_out`=1.
  - `rsp_valid` at +4 edges; follower memory[0x0406]=8'hDC.
- Read 16'h0406 with follower dataValid 3 cycles after LOWER → `rsp_rdata`=8'hDC, `rsp_timeout`=0, `bus_read`=1 only in LOWER.
- Back-to-back: write 0x0407←8'hAB, read 0x0406, read 0x0407 with `req_valid` held high → new UPPER starts in the cycle after each `rsp_valid`. Reads return 8'hDC then 8'hAB.
- Timeout: TIMEOUT=4, no follower response to read 0x1234 → exactly 4 RDWAIT cycles, then `rsp_valid`, `rsp_timeout`=1, `rsp_rdata`=8'hFF.
- Timeout race: TIMEOUT=4, dataValid with data 8'h5A on the 4th RDWAIT cycle → `rsp_rdata`=8'h5A, `rsp_timeout`=0.

Source files
------------

// File: rtl/simplebus_leader_ctrl.sv
// Leader-side simplebus controller: turns client read/write requests into the
// two-cycle address phase plus a read-wait or single write-data cycle.
module simplebus_leader_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic        bus_start,
    output logic        bus_read,
    output logic [7:0]  bus_addr_out,
    output logic        bus_addr_oe,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_in,
    output logic        bus_dv_out,
    output logic        bus_dv_oe,
    input  logic        bus_dv_in,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UPPER  = 3'd1,
        ST_LOWER  = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_WRDATA = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] addr_q;
    logic        write_q;
    logic [7:0]  wdata_q;
    logic [7:0]  wait_cnt;

    // A request transfers on a clock edge where req_valid && req_ready; the
    // client holds req_* stable until then. rsp_valid is a one-cycle pulse
    // with no backpressure.
    assign req_ready = (state == ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            addr_q      <= 16'h0000;
            write_q     <= 1'b0;
            wdata_q     <= 8'h00;
            wait_cnt    <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        state   <= ST_UPPER;
                    end
                end
                ST_UPPER: state <= ST_LOWER;
                ST_LOWER: begin
                    wait_cnt <= 8'h00;
                    state    <= write_q ? ST_WRDATA : ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    // dataValid takes priority over a timeout in the same cycle
                    if (bus_dv_in) begin
                        rsp_rdata   <= bus_data_in;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_rdata   <= 8'hFF;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WRDATA: begin
                    rsp_timeout <= 1'b0;
                    rsp_valid   <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus drive decodes only from state and the latched request.
    always_comb begin
        bus_start    = 1'b0;
        bus_read     = 1'b0;
        bus_addr_out = 8'h00;
        bus_addr_oe  = 1'b0;
        bus_data_out = 8'h00;
        bus_data_oe  = 1'b0;
        bus_dv_out   = 1'b0;
        bus_dv_oe    = 1'b0;
        case (state)
            ST_UPPER: begin
                bus_start    = 1'b1;
                bus_addr_out = addr_q[15:8];
                bus_addr_oe  = 1'b1;
            end
            ST_LOWER: begin
                bus_addr_out = addr_q[7:0];
                bus_addr_oe  = 1'b1;
                bus_read     = ~write_q;
            end
            ST_WRDATA: begin
                bus_data_out = wdata_q;
                bus_data_oe  = 1'b1;
                bus_dv_out   = 1'b1;
                bus_dv_oe    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simplebus_leader_ctrl.sv
// Bench for simplebus_leader_ctrl: memory follower, directed vector table,
// reset corner case and randomized traffic against a transaction-level model.
module tb_simplebus_leader_ctrl;

    localparam int TO = 4;

    logic        clock, resetN;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic        bus_start, bus_read, bus_addr_oe, bus_data_oe, bus_dv_out, bus_dv_oe, bus_dv_in;
    logic [7:0]  bus_addr_out, bus_data_out, bus_data_in;
    logic [2:0]  dbg_state;

    simplebus_leader_ctrl #(.TIMEOUT(TO)) dut (
        .clock(clock), .resetN(resetN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .bus_start(bus_start), .bus_read(bus_read),
        .bus_addr_out(bus_addr_out), .bus_addr_oe(bus_addr_oe),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
        .bus_dv_out(bus_dv_out), .bus_dv_oe(bus_dv_oe), .bus_dv_in(bus_dv_in),
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // delay: RDWAIT cycle (1-based) in which the follower answers; 0 = never
    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          delay;
        logic [7:0]  exp_rdata;
        logic        exp_to;
        int          exp_lat;
    } txn_t;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_bus(input logic st, input logic rd, input logic aoe,
                                             input logic [7:0] aout, input logic doe,
                                             input logic [7:0] dout, input logic dvoe,
                                             input logic dvout);
        return {10'b0, st, rd, aoe, aout, doe, dout, dvoe, dvout};
    endfunction

    function automatic logic [31:0] bus_vec();
        return pack_bus(bus_start, bus_read, bus_addr_oe, bus_addr_oe ? bus_addr_out : 8'h00,
                        bus_data_oe, bus_data_oe ? bus_data_out : 8'h00,
                        bus_dv_oe, bus_dv_oe & bus_dv_out);
    endfunction

    // ---------------- memory follower ----------------
    logic [7:0]  f_mem [logic [15:0]];
    logic [15:0] f_addr;
    logic        f_rd;
    int          f_phase, f_j, f_d, f_delay;

    initial begin
        bus_dv_in = 1'b0;
        bus_data_in = 8'h00;
        f_phase = 0; f_j = 0; f_d = 0; f_rd = 1'b0; f_addr = 16'h0000;
        forever begin
            @(negedge clock);
            bus_dv_in = 1'b0;
            bus_data_in = 8'($urandom);
            if (!resetN) begin
                f_phase = 0;
            end else if (bus_start && bus_addr_oe) begin
                f_addr[15:8] = bus_addr_out;
                f_d = f_delay;
                f_phase = 1;
            end else if (f_phase == 1 && bus_addr_oe) begin
                f_addr[7:0] = bus_addr_out;
                f_rd = bus_read;
                f_j = 0;
                f_phase = 2;
            end else if (f_phase == 2) begin
                if (!f_rd) begin
                    if (bus_data_oe && bus_dv_oe && bus_dv_out) f_mem[f_addr] = bus_data_out;
                    f_phase = 0;
                end else begin
                    f_j++;
                    if (f_j == f_d) begin
                        bus_dv_in = 1'b1;
                        bus_data_in = f_mem.exists(f_addr) ? f_mem[f_addr] : 8'h00;
                        f_phase = 0;
                    end
                end
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] ref_rdata = 8'h00;

    function automatic txn_t predict(input txn_t t);
        txn_t r = t;
        if (t.write) begin
            ref_mem[t.addr] = t.wdata;
            r.exp_rdata = ref_rdata;
            r.exp_to = 1'b0;
            r.exp_lat = 4;
        end else if (t.delay >= 1 && t.delay <= TO) begin
            r.exp_rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : 8'h00;
            r.exp_to = 1'b0;
            r.exp_lat = 3 + t.delay;
        end else begin
            r.exp_rdata = 8'hFF;
            r.exp_to = 1'b1;
            r.exp_lat = 3 + TO;
        end
        ref_rdata = r.exp_rdata;
        return r;
    endfunction

    // Presents t at the current negedge and checks every cycle up to the response.
    task automatic run_txn(input txn_t t);
        int g = 0;
        logic [31:0] exp;
        logic last;
        f_delay = t.delay;
        req_valid = 1'b1;
        req_write = t.write;
        req_addr = t.addr;
        req_wdata = t.wdata;
        while (!req_ready && g < 64) begin
            @(negedge clock);
            g++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        for (int c = 1; c <= t.exp_lat; c++) begin
            @(negedge clock);
            req_write = 1'($urandom);
            req_addr = 16'($urandom);
            req_wdata = 8'($urandom);
            if (c == 1)              exp = pack_bus(1'b1, 1'b0, 1'b1, t.addr[15:8], 1'b0, 8'h00, 1'b0, 1'b0);
            else if (c == 2)         exp = pack_bus(1'b0, ~t.write, 1'b1, t.addr[7:0], 1'b0, 8'h00, 1'b0, 1'b0);
            else if (c == 3 && t.write) exp = pack_bus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, t.wdata, 1'b1, 1'b1);
            else                     exp = 32'd0;
            chk($sformatf("bus_cycle%0d", c), bus_vec(), exp);
            last = (c == t.exp_lat);
            chk("req_ready", 32'(req_ready), 32'(last));
            chk("rsp_valid", 32'(rsp_valid), 32'(last));
            if (last) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(t.exp_rdata));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(t.exp_to));
                if (t.write)
                    chk("follower_mem", 32'(f_mem.exists(t.addr) ? f_mem[t.addr] : 8'h00), 32'(t.wdata));
            end
        end
    endtask

    txn_t tbl [11];
    txn_t t;

    initial begin
        // Directed vectors, applied back to back with req_valid held high.
        tbl[0]  = '{1'b1, 16'h0406, 8'hDC, 0, 8'h00, 1'b0, 4};
        tbl[1]  = '{1'b0, 16'h0406, 8'h00, 3, 8'hDC, 1'b0, 6};
        tbl[2]  = '{1'b1, 16'h0407, 8'hAB, 0, 8'hDC, 1'b0, 4};
        tbl[3]  = '{1'b0, 16'h0406, 8'h00, 1, 8'hDC, 1'b0, 4};
        tbl[4]  = '{1'b0, 16'h0407, 8'h00, 2, 8'hAB, 1'b0, 5};
        tbl[5]  = '{1'b0, 16'h1234, 8'h00, 0, 8'hFF, 1'b1, 7};
        tbl[6]  = '{1'b1, 16'h2000, 8'h5A, 0, 8'hFF, 1'b0, 4};
        tbl[7]  = '{1'b0, 16'h2000, 8'h00, 4, 8'h5A, 1'b0, 7};
        tbl[8]  = '{1'b0, 16'h1234, 8'h00, 5, 8'hFF, 1'b1, 7};
        tbl[9]  = '{1'b1, 16'h0406, 8'h11, 0, 8'hFF, 1'b0, 4};
        tbl[10] = '{1'b0, 16'h0406, 8'h00, 2, 8'h11, 1'b0, 5};

        resetN = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
        f_delay = 0;
        repeat (2) @(negedge clock);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp", 32'({rsp_valid, rsp_timeout, rsp_rdata}), 32'd0);
        chk("reset_bus_raw", 32'({bus_start, bus_read, bus_addr_out, bus_addr_oe, bus_data_out,
                                  bus_data_oe, bus_dv_out, bus_dv_oe}), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        resetN = 1'b1;
        @(negedge clock);

        // Reset asserted in the middle of UPPER must abort with no response.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBEEF;
        @(negedge clock);
        chk("upper_before_reset", 32'(bus_start), 32'd1);
        resetN = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("async_reset_bus", bus_vec(), 32'd0);
        chk("async_reset_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_reset_bus", bus_vec(), 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            t = predict(tbl[i]);
            run_txn(tbl[i]);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            t.write = 1'($urandom_range(0, 1));
            t.addr = {8'($urandom_range(0, 1)), 8'($urandom_range(0, 3))};
            t.wdata = 8'($urandom);
            t.delay = $urandom_range(0, TO + 1);
            t = predict(t);
            run_txn(t);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
